// File: rtl/customer_pkg.sv
// customer_pkg
// Shared widths, limits and the evaluation-result type for the vending
// purchase evaluator (customer / customer_check).
package customer_pkg;

    localparam int PRICE_W   = 4;
    localparam int AMT_W     = 4;
    localparam int MONEY_W   = 4;
    localparam int SUPPLY_W  = 4;
    localparam int ACC_W     = 5;
    localparam int COST_W    = 8;
    localparam int ACC_SUM_W = 9;
    localparam int ACC_MAX   = 31;

    typedef struct packed {
        logic              ok;
        logic [COST_W-1:0] cost;
        logic [AMT_W-1:0]  units;
    } eval_t;

endpackage

// File: rtl/customer_check.sv
// customer_check
// Purely combinational sale evaluation: cost, units sold, accumulator sum and
// the sale-valid flag.
// Optional feature macro: CUSTOMER_PARTIAL_VEND_EN (sell as many units as the
// customer's money and the stock allow instead of all-or-nothing).
// Ports:
//   price, amount, money, acc, supply : purchase inputs
//   o_res     : {ok, cost, units}
//   o_acc_new : accumulator after a valid sale
module customer_check
    import customer_pkg::*;
(
    input  logic [PRICE_W-1:0]  price,
    input  logic [AMT_W-1:0]    amount,
    input  logic [MONEY_W-1:0]  money,
    input  logic [ACC_W-1:0]    acc,
    input  logic [SUPPLY_W-1:0] supply,
    output eval_t               o_res,
    output logic [ACC_W-1:0]    o_acc_new
);

    logic [AMT_W-1:0]     w_units;
    logic [COST_W-1:0]    w_cost;
    logic [ACC_SUM_W-1:0] w_acc_sum;
    logic                 w_ok;

`ifdef CUSTOMER_PARTIAL_VEND_EN
    logic [MONEY_W-1:0] w_quot;

    always_comb begin
        w_quot  = '0;
        w_units = amount;
        // division skipped when price is zero; that case rejects anyway
        if (price != '0) begin
            w_quot = money / price;
        end
        if (supply < w_units) begin
            w_units = supply;
        end
        if (w_quot < w_units) begin
            w_units = w_quot;
        end
    end

    assign w_cost    = COST_W'(price) * COST_W'(w_units);
    assign w_acc_sum = ACC_SUM_W'(acc) + ACC_SUM_W'(w_cost);
    // money and stock are satisfied by construction of w_units
    assign w_ok      = (price != '0) && (amount != '0) && (w_units != '0) &&
                       (w_acc_sum <= ACC_SUM_W'(ACC_MAX));
`else
    assign w_units   = amount;
    assign w_cost    = COST_W'(price) * COST_W'(amount);
    assign w_acc_sum = ACC_SUM_W'(acc) + ACC_SUM_W'(w_cost);
    assign w_ok      = (price != '0) && (amount != '0) &&
                       (COST_W'(money) >= w_cost) && (supply >= amount) &&
                       (w_acc_sum <= ACC_SUM_W'(ACC_MAX));
`endif

    assign o_res.ok    = w_ok;
    assign o_res.cost  = w_cost;
    assign o_res.units = w_units;
    assign o_acc_new   = w_acc_sum[ACC_W-1:0];

endmodule

// File: rtl/customer.sv
// customer
// Vending-machine purchase evaluator. Registers the updated customer money,
// stock and machine accumulator on a valid sale; otherwise lights redLight and
// registers the inputs unchanged. One cycle latency, synchronous active-low
// reset clears every output.
// Optional feature macro: CUSTOMER_PARTIAL_VEND_EN (see customer_check).
// Ports:
//   clk, rst_n                                 : clock, sync active-low reset
//   price, amount, money, mahcineAcc, supply   : purchase inputs
//   redLight                                   : 1 = sale rejected
//   machineAcc_out, money_out, supply_out      : registered results
module customer
    import customer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PRICE_W-1:0]  price,
    input  logic [AMT_W-1:0]    amount,
    input  logic [MONEY_W-1:0]  money,
    input  logic [ACC_W-1:0]    mahcineAcc,
    input  logic [SUPPLY_W-1:0] supply,
    output logic                redLight,
    output logic [ACC_W-1:0]    machineAcc_out,
    output logic [MONEY_W-1:0]  money_out,
    output logic [SUPPLY_W-1:0] supply_out
);

    eval_t            w_res;
    logic [ACC_W-1:0] w_acc_new;

    customer_check u_check (
        .price     (price),
        .amount    (amount),
        .money     (money),
        .acc       (mahcineAcc),
        .supply    (supply),
        .o_res     (w_res),
        .o_acc_new (w_acc_new)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redLight       <= 1'b0;
            machineAcc_out <= '0;
            money_out      <= '0;
            supply_out     <= '0;
        end else if (w_res.ok) begin
            redLight       <= 1'b0;
            machineAcc_out <= w_acc_new;
            // cost <= money on a valid sale, so the low bits hold the result
            money_out      <= MONEY_W'(COST_W'(money) - w_res.cost);
            supply_out     <= supply - w_res.units;
        end else begin
            redLight       <= 1'b1;
            machineAcc_out <= mahcineAcc;
            money_out      <= money;
            supply_out     <= supply;
        end
    end

endmodule

// File: tb/tb_customer.sv
module tb_customer;

    logic       clk;
    logic       rst_n;
    logic [3:0] price;
    logic [3:0] amount;
    logic [3:0] money;
    logic [4:0] mahcineAcc;
    logic [3:0] supply;
    logic       redLight;
    logic [4:0] machineAcc_out;
    logic [3:0] money_out;
    logic [3:0] supply_out;

    int tests;
    int fails;
    bit chk_en;

    int exp_red, exp_money, exp_supply, exp_acc;

    customer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .price          (price),
        .amount         (amount),
        .money          (money),
        .mahcineAcc     (mahcineAcc),
        .supply         (supply),
        .redLight       (redLight),
        .machineAcc_out (machineAcc_out),
        .money_out      (money_out),
        .supply_out     (supply_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain integer arithmetic on the sale rules.
    function automatic void model(input int p, input int a, input int m,
                                  input int acc, input int s,
                                  output int r, output int mo,
                                  output int so, output int ao);
        int  units;
        int  cost;
        bit  ok;
`ifdef CUSTOMER_PARTIAL_VEND_EN
        if (p == 0 || a == 0) begin
            units = 0;
            ok    = 0;
        end else begin
            units = a;
            if (s < units) units = s;
            if (m / p < units) units = m / p;
            ok = (units > 0);
        end
        cost = p * units;
        if (acc + cost > 31) ok = 0;
`else
        units = a;
        cost  = p * a;
        ok    = (p != 0) && (a != 0) && (m >= cost) && (s >= a) && (acc + cost <= 31);
`endif
        if (ok) begin
            r = 0; mo = m - cost; so = s - units; ao = acc + cost;
        end else begin
            r = 1; mo = m; so = s; ao = acc;
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_red = 0; exp_money = 0; exp_supply = 0; exp_acc = 0;
        end else begin
            model(int'(price), int'(amount), int'(money), int'(mahcineAcc), int'(supply),
                  exp_red, exp_money, exp_supply, exp_acc);
        end
    end

    task automatic cmp(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // compare process: every cycle after the first reset edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_redLight", int'(redLight), exp_red);
            cmp("model_money_out", int'(money_out), exp_money);
            cmp("model_supply_out", int'(supply_out), exp_supply);
            cmp("model_acc_out", int'(machineAcc_out), exp_acc);
        end
    end

    task automatic drive(input int p, input int a, input int m, input int acc, input int s);
        price      = 4'(p);
        amount     = 4'(a);
        money      = 4'(m);
        mahcineAcc = 5'(acc);
        supply     = 4'(s);
    endtask

    // Called with time just after a negedge: apply inputs, step one edge,
    // check hand-computed literals, return at the next negedge.
    task automatic vec(input string name, input int p, input int a, input int m,
                       input int acc, input int s,
                       input int er, input int em, input int es, input int ea);
        drive(p, a, m, acc, s);
        @(posedge clk);
        #1;
        cmp({name, "_red"}, int'(redLight), er);
        cmp({name, "_money"}, int'(money_out), em);
        cmp({name, "_supply"}, int'(supply_out), es);
        cmp({name, "_acc"}, int'(machineAcc_out), ea);
        @(negedge clk);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        chk_en = 0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        cmp("reset_red", int'(redLight), 0);
        cmp("reset_money", int'(money_out), 0);
        rst_n = 1'b1;

        vec("valid_basic", 3, 2, 6, 0, 4, 0, 0, 2, 6);
`ifdef CUSTOMER_PARTIAL_VEND_EN
        vec("short_money", 3, 2, 5, 0, 4, 0, 2, 3, 3);
        vec("short_supply", 2, 5, 15, 0, 4, 0, 7, 0, 8);
        vec("cost_over15", 4, 5, 15, 0, 9, 0, 3, 6, 12);
`else
        vec("short_money", 3, 2, 5, 0, 4, 1, 5, 4, 0);
        vec("short_supply", 2, 5, 15, 0, 4, 1, 15, 4, 0);
        vec("cost_over15", 4, 5, 15, 0, 9, 1, 15, 9, 0);
`endif
        vec("acc_overflow", 5, 3, 15, 20, 9, 1, 15, 9, 20);
        vec("acc_eq31", 5, 3, 15, 16, 9, 0, 0, 6, 31);
        vec("price_zero", 0, 2, 9, 4, 3, 1, 9, 3, 4);
        vec("amount_zero", 2, 0, 9, 4, 3, 1, 9, 3, 4);
        vec("supply_eq_amt", 1, 3, 5, 0, 3, 0, 2, 0, 3);

        // reset mid-sequence while inputs form a valid sale
        drive(3, 2, 6, 0, 4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cmp("midreset_red", int'(redLight), 0);
        cmp("midreset_money", int'(money_out), 0);
        cmp("midreset_supply", int'(supply_out), 0);
        cmp("midreset_acc", int'(machineAcc_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        vec("after_reset", 3, 2, 6, 0, 4, 0, 0, 2, 6);

        // random stream, checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 15)));
            rst_n = ($urandom_range(0, 15) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
